ro_puf_array_ctrl: RTL and testbench

- Parametrised successor to the single ring-oscillator PUF top: a synchronous controller for N_CH ring-oscillator channels.
- Gates the oscillators on and synchronises their outputs into the clk domain, then counts rising edges per channel.
- Derives one response bit per adjacent channel pair using one of two modes: fixed-window count comparison or race-to-threshold.
- Sits between the oscillator macro array and the key/response readout logic.

---
 rtl/ro_puf_array_ctrl.sv | 161 ++++++++++++++++
 tb/tb_ro_puf_array_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ro_puf_array_ctrl.sv
// Multi-channel ring-oscillator PUF controller: gates N_CH oscillators, counts synchronised edges,
// and derives one response bit per adjacent channel pair by window comparison or race-to-threshold.
module ro_puf_array_ctrl #(
    parameter int N_CH         = 8,
    parameter int CNT_BIT_SIZE = 16,
    parameter int WIN_BIT_SIZE = 16,
    parameter int SETTLE_CYC   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_start,
    input  logic                         i_mode,
    input  logic [WIN_BIT_SIZE-1:0]      i_win_len,
    input  logic [CNT_BIT_SIZE-1:0]      i_cnt_set,
    input  logic [N_CH-1:0]              i_ro,
    output logic [N_CH-1:0]              o_ro_en,
    output logic                         o_busy,
    output logic                         o_valid,
    output logic [N_CH/2-1:0]            o_response,
    output logic [N_CH/2-1:0]            o_tie,
    output logic                         o_timeout,
    output logic [N_CH*CNT_BIT_SIZE-1:0] o_count
);
    localparam int N_PAIR = N_CH / 2;
    localparam int SET_W  = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, COUNT, RESOLVE} state_t;

    state_t                    state_reg, state_next;
    logic                      rst_meta_reg, rst_n_sync;
    logic [N_CH-1:0]           sync1_reg, sync2_reg, prev_reg, edge_det;
    logic                      mode_reg;
    logic [WIN_BIT_SIZE-1:0]   win_reg, win_cnt_reg;
    logic [CNT_BIT_SIZE-1:0]   thr_reg;
    logic [SET_W-1:0]          settle_cnt_reg;
    logic [CNT_BIT_SIZE-1:0]   cnt_reg  [N_CH];
    logic [CNT_BIT_SIZE-1:0]   cnt_next [N_CH];
    logic [N_CH-1:0]           cnt_inc, reach;
    logic [N_PAIR-1:0]         decided_reg, race_resp_reg, race_tie_reg;
    logic [N_PAIR-1:0]         pair_hit, hit_resp, hit_tie, cmp_resp, cmp_tie;
    logic                      counting, all_decided, win_last;

    // Reset asserts asynchronously but releases on a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_reg <= 1'b0;
            rst_n_sync   <= 1'b0;
        end else begin
            rst_meta_reg <= 1'b1;
            rst_n_sync   <= rst_meta_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            prev_reg  <= '0;
        end else begin
            sync1_reg <= i_ro;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign edge_det    = sync2_reg & ~prev_reg;
    assign counting    = (state_reg == COUNT);
    assign win_last    = (win_cnt_reg == win_reg - WIN_BIT_SIZE'(1));
    assign all_decided = &(decided_reg | pair_hit);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            // In race mode a decided pair's counters stop moving
            assign cnt_inc[gi]  = counting && edge_det[gi] && !(mode_reg && decided_reg[gi/2])
                                  && (cnt_reg[gi] != '1);
            assign cnt_next[gi] = cnt_reg[gi] + CNT_BIT_SIZE'(cnt_inc[gi]);
            assign reach[gi]    = (cnt_next[gi] >= thr_reg);
            assign o_count[gi*CNT_BIT_SIZE +: CNT_BIT_SIZE] = cnt_reg[gi];
        end
        for (gi = 0; gi < N_PAIR; gi++) begin : g_pair
            assign pair_hit[gi] = counting && mode_reg && !decided_reg[gi]
                                  && (reach[2*gi] || reach[2*gi+1]);
            assign hit_resp[gi] = reach[2*gi] && !reach[2*gi+1];
            assign hit_tie[gi]  = reach[2*gi] && reach[2*gi+1];
            assign cmp_resp[gi] = (cnt_reg[2*gi] > cnt_reg[2*gi+1]);
            assign cmp_tie[gi]  = (cnt_reg[2*gi] == cnt_reg[2*gi+1]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) state_reg <= IDLE;
        else             state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (i_start) state_next = SETTLE;
            SETTLE:  if (settle_cnt_reg == SET_W'(SETTLE_CYC - 1)) state_next = COUNT;
            COUNT:   if ((mode_reg && all_decided) || win_last) state_next = RESOLVE;
            RESOLVE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            mode_reg       <= 1'b0;
            win_reg        <= '0;
            thr_reg        <= '0;
            win_cnt_reg    <= '0;
            settle_cnt_reg <= '0;
            decided_reg    <= '0;
            race_resp_reg  <= '0;
            race_tie_reg   <= '0;
            o_valid        <= 1'b0;
            o_response     <= '0;
            o_tie          <= '0;
            o_timeout      <= 1'b0;
            for (int c = 0; c < N_CH; c++) cnt_reg[c] <= '0;
        end else begin
            o_valid <= 1'b0;
            case (state_reg)
                IDLE: if (i_start) begin
                    mode_reg       <= i_mode;
                    win_reg        <= (i_win_len == '0) ? WIN_BIT_SIZE'(1) : i_win_len;
                    thr_reg        <= (i_cnt_set == '0) ? CNT_BIT_SIZE'(1) : i_cnt_set;
                    settle_cnt_reg <= '0;
                    decided_reg    <= '0;
                    race_resp_reg  <= '0;
                    race_tie_reg   <= '0;
                    for (int c = 0; c < N_CH; c++) cnt_reg[c] <= '0;
                end
                SETTLE: begin
                    settle_cnt_reg <= settle_cnt_reg + SET_W'(1);
                    win_cnt_reg    <= '0;
                end
                COUNT: begin
                    win_cnt_reg   <= win_cnt_reg + WIN_BIT_SIZE'(1);
                    decided_reg   <= decided_reg | pair_hit;
                    race_resp_reg <= race_resp_reg | (pair_hit & hit_resp);
                    race_tie_reg  <= race_tie_reg | (pair_hit & hit_tie);
                    for (int c = 0; c < N_CH; c++) cnt_reg[c] <= cnt_next[c];
                end
                RESOLVE: begin
                    // Pairs not settled by the race fall back to a count comparison
                    o_response <= (decided_reg & race_resp_reg) | (~decided_reg & cmp_resp);
                    o_tie      <= (decided_reg & race_tie_reg) | (~decided_reg & cmp_tie);
                    o_timeout  <= mode_reg && !(&decided_reg);
                    o_valid    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_ro_en = {N_CH{(state_reg == SETTLE) || (state_reg == COUNT)}};
    assign o_busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_ro_puf_array_ctrl.sv
// Directed bench for ro_puf_array_ctrl with N_CH=4: oscillators are free-running clocks gated by o_ro_en.
`timescale 1ns/1ps
module tb_ro_puf_array_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start, i_mode;
    logic [15:0] i_win_len;
    logic [7:0]  i_cnt_set;
    logic [3:0]  i_ro, osc;
    logic [3:0]  o_ro_en;
    logic        o_busy, o_valid, o_timeout;
    logic [1:0]  o_response, o_tie;
    logic [31:0] o_count;
    real         half [4];
    int          checks = 0;
    int          failures = 0;
    int          lat;

    ro_puf_array_ctrl #(.N_CH(4), .CNT_BIT_SIZE(8), .WIN_BIT_SIZE(16), .SETTLE_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_mode(i_mode),
        .i_win_len(i_win_len), .i_cnt_set(i_cnt_set), .i_ro(i_ro),
        .o_ro_en(o_ro_en), .o_busy(o_busy), .o_valid(o_valid),
        .o_response(o_response), .o_tie(o_tie), .o_timeout(o_timeout), .o_count(o_count)
    );

    always #5 clk = ~clk;

    initial osc = 4'b0;
    for (genvar gi = 0; gi < 4; gi++) begin : g_osc
        always begin
            if (half[gi] > 0.0) begin
                #(half[gi]) osc[gi] = ~osc[gi];
            end else begin
                osc[gi] = 1'b0;
                #1;
            end
        end
    end
    assign i_ro = osc & o_ro_en;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s got=%0d", tag, got);
        end
    endtask

    function automatic int cnt(input int c);
        return int'(o_count[c*8 +: 8]);
    endfunction

    // Starts an evaluation and returns the number of rising edges until o_valid (-1 if never)
    task automatic run_eval(input logic mode, input int win, input int thr,
                            input int stray_at, input int budget, output int latency);
        @(negedge clk);
        i_mode    = mode;
        i_win_len = 16'(win);
        i_cnt_set = 8'(thr);
        i_start   = 1'b1;
        latency   = -1;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk);
            #1;
            i_start = (n == stray_at);
            if (o_valid) begin
                latency = n;
                break;
            end
        end
        i_start = 1'b0;
        check_val("valid_seen", int'(latency > 0), 1);
        check_val("busy_at_valid", int'(o_busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;
        rst_n = 1'b0; i_start = 1'b0; i_mode = 1'b0; i_win_len = '0; i_cnt_set = '0;
        for (int c = 0; c < 4; c++) half[c] = 0.0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ro_en", int'(o_ro_en), 0);
        check_val("rst_busy", int'(o_busy), 0);
        check_val("rst_valid", int'(o_valid), 0);
        check_val("rst_resp", int'(o_response), 0);
        check_val("rst_tie", int'(o_tie), 0);
        check_val("rst_timeout", int'(o_timeout), 0);
        check_val("rst_count", int'(o_count), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Window mode: 23 ns vs 47 ns over 100 cycles
        half[0] = 11.5; half[1] = 23.5;
        run_eval(1'b0, 100, 0, 0, 200, lat);
        check_val("win_latency", lat, 106);
        check_val("win_cnt0_range", int'(cnt(0) >= 42 && cnt(0) <= 44), 1);
        check_val("win_cnt1_range", int'(cnt(1) >= 20 && cnt(1) <= 22), 1);
        check_val("win_resp0", int'(o_response[0]), 1);
        check_val("win_tie0", int'(o_tie[0]), 0);

        // Saturation: both channels of pair 1 clip at 255 and tie
        half[2] = 11.5; half[3] = 11.5;
        run_eval(1'b0, 1000, 0, 0, 1200, lat);
        check_val("sat_latency", lat, 1006);
        check_val("sat_cnt2", cnt(2), 255);
        check_val("sat_cnt3", cnt(3), 255);
        check_val("sat_resp1", int'(o_response[1]), 0);
        check_val("sat_tie1", int'(o_tie[1]), 1);
        check_val("sat_resp0", int'(o_response[0]), 1);

        // Race mode: pair 0 won by ch1, pair 1 won by ch2
        half[0] = 15.5; half[1] = 11.5; half[2] = 11.5; half[3] = 20.5;
        run_eval(1'b1, 500, 20, 0, 600, lat);
        check_val("race_resp", int'(o_response), 2);
        check_val("race_tie", int'(o_tie), 0);
        check_val("race_timeout", int'(o_timeout), 0);
        check_val("race_cnt1", cnt(1), 20);
        check_val("race_cnt2", cnt(2), 20);
        check_val("race_cnt0_lt", int'(cnt(0) < 20), 1);
        check_val("race_cnt3_lt", int'(cnt(3) < 20), 1);

        // Race timeout, started back-to-back in the o_valid cycle
        half[0] = 15.5; half[1] = 0.0; half[2] = 11.5; half[3] = 0.0;
        run_eval(1'b1, 50, 200, 0, 100, lat);
        check_val("to_latency", lat, 56);
        check_val("to_timeout", int'(o_timeout), 1);
        check_val("to_resp", int'(o_response), 3);
        check_val("to_tie", int'(o_tie), 0);

        // Stray start during COUNT is ignored
        run_eval(1'b0, 30, 0, 15, 100, lat);
        check_val("stray_latency", lat, 36);
        check_val("timeout_cleared", int'(o_timeout), 0);
        @(posedge clk);
        #1;
        check_val("valid_one_cycle", int'(o_valid), 0);

        // Reset in the middle of COUNT
        @(negedge clk);
        i_mode = 1'b0; i_win_len = 16'd100; i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        repeat (30) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("abort_ro_en", int'(o_ro_en), 0);
        check_val("abort_busy", int'(o_busy), 0);
        check_val("abort_resp", int'(o_response), 0);
        vcount = 0;
        repeat (3) begin
            @(posedge clk);
            #1 vcount += int'(o_valid);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (120) begin
            @(posedge clk);
            #1 vcount += int'(o_valid);
        end
        check_val("abort_no_valid", vcount, 0);

        half[0] = 11.5; half[1] = 23.5; half[2] = 0.0; half[3] = 0.0;
        run_eval(1'b0, 100, 0, 0, 200, lat);
        check_val("post_rst_latency", lat, 106);
        check_val("post_rst_resp0", int'(o_response[0]), 1);
        check_val("post_rst_cnt0_range", int'(cnt(0) >= 42 && cnt(0) <= 44), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
